// File: rtl/checkers_pkg.sv
// Shared board geometry, scanner state encoding and square indexing for the
// checkers sensor hardware.
package checkers_pkg;

    localparam int NUM_ROWS    = 8;
    localparam int NUM_COLS    = 4;
    localparam int NUM_SQUARES = NUM_ROWS * NUM_COLS;
    localparam int ROW_W       = $clog2(NUM_ROWS);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        PUBLISH
    } scan_state_t;

    function automatic int square_index(input int row, input int col);
        return row * NUM_COLS + col;
    endfunction

endpackage

// File: rtl/square_debounce.sv
// One debounced occupancy bit: flips only after DEBOUNCE_SCANS consecutive
// disagreeing samples, each sample qualified by sample_en.
module square_debounce #(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic clk,
    input  logic srst,
    input  logic sample_en,
    input  logic sample,
    output logic debounced
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] LAST_MISS = CW'(DEBOUNCE_SCANS - 1);

    logic          debounced_reg;
    logic [CW-1:0] miss_cnt_reg;

    // The counter never holds DEBOUNCE_SCANS itself: reaching it flips and clears
    // in the same cycle, so it can never wrap.
    always_ff @(posedge clk) begin
        if (srst) begin
            debounced_reg <= 1'b0;
            miss_cnt_reg  <= '0;
        end else if (sample_en) begin
            if (sample == debounced_reg) begin
                miss_cnt_reg <= '0;
            end else if (miss_cnt_reg == LAST_MISS) begin
                debounced_reg <= ~debounced_reg;
                miss_cnt_reg  <= '0;
            end else begin
                miss_cnt_reg <= miss_cnt_reg + 1'b1;
            end
        end
    end

    assign debounced = debounced_reg;

endmodule

// File: rtl/sensor_scanner.sv
// Row-scanned, per-square debounced piece sensor matrix with an atomic per-frame
// occupancy publish. Define SENSOR_ACTIVE_LOW_EN for sensors that pull low on a piece.
module sensor_scanner
    import checkers_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_COLS-1:0]    col_in,
    output logic [NUM_ROWS-1:0]    row_sel,
    output logic [NUM_SQUARES-1:0] sensor_board,
    output logic                   frame_done,
    output logic                   board_changed
);

    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam logic [SW-1:0]    LAST_SETTLE = SW'(SETTLE_CYCLES - 1);
    localparam logic [ROW_W-1:0] LAST_ROW    = ROW_W'(NUM_ROWS - 1);

    logic [NUM_COLS-1:0]    sync1_reg, sync2_reg;
    logic [NUM_COLS-1:0]    sample_bits;
    logic [NUM_SQUARES-1:0] deb_vec;

    scan_state_t      state_reg, state_next;
    logic [ROW_W-1:0] row_reg, row_next;
    logic [SW-1:0]    cnt_reg, cnt_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= col_in;
            sync2_reg <= sync1_reg;
        end
    end

`ifdef SENSOR_ACTIVE_LOW_EN
    assign sample_bits = ~sync2_reg;
`else
    assign sample_bits = sync2_reg;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            row_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            row_reg   <= row_next;
            cnt_reg   <= cnt_next;
        end
    end

    // enable is only looked at in IDLE, so a started frame always runs to PUBLISH.
    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (enable) begin
                    row_next   = '0;
                    cnt_next   = '0;
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_reg == LAST_SETTLE) begin
                    state_next = SAMPLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            SAMPLE: begin
                if (row_reg == LAST_ROW) begin
                    state_next = PUBLISH;
                end else begin
                    row_next   = row_reg + 1'b1;
                    cnt_next   = '0;
                    state_next = DRIVE;
                end
            end
            PUBLISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        row_sel = '0;
        if (state_reg == DRIVE || state_reg == SAMPLE) begin
            row_sel = NUM_ROWS'(1) << row_reg;
        end
    end

    genvar gi, gc;
    generate
        for (gi = 0; gi < NUM_ROWS; gi++) begin : g_row
            for (gc = 0; gc < NUM_COLS; gc++) begin : g_col
                square_debounce #(
                    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
                ) u_square (
                    .clk       (clock),
                    .srst      (reset),
                    .sample_en ((state_reg == SAMPLE) && (row_reg == ROW_W'(gi))),
                    .sample    (sample_bits[gc]),
                    .debounced (deb_vec[square_index(gi, gc)])
                );
            end
        end
    endgenerate

    // The whole word is loaded in one edge so readers never see a mixed frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            sensor_board  <= '0;
            frame_done    <= 1'b0;
            board_changed <= 1'b0;
        end else begin
            frame_done    <= (state_reg == PUBLISH);
            board_changed <= (state_reg == PUBLISH) && (deb_vec != sensor_board);
            if (state_reg == PUBLISH) begin
                sensor_board <= deb_vec;
            end
        end
    end

endmodule

// File: tb/tb_sensor_scanner.sv
// Randomized frame-level bench for sensor_scanner with a per-square debounce model.
module tb_sensor_scanner;

    localparam int SETTLE = 4;
    localparam int DEB    = 2;
    localparam int PERIOD = 8 * (SETTLE + 1) + 2;

`ifdef SENSOR_ACTIVE_LOW_EN
    localparam logic [3:0] INV = 4'hF;
`else
    localparam logic [3:0] INV = 4'h0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  col_in = 4'h0;
    logic [7:0]  row_sel;
    logic [31:0] sensor_board;
    logic        frame_done;
    logic        board_changed;

    int checks = 0;
    int fails  = 0;

    // Presence map the "physical board" currently shows; bit = row*4 + col.
    logic [31:0] cur_pat = 32'h0;

    // Reference model state.
    int          mdeb [32];
    int          mcnt [32];
    logic [31:0] exp_board;
    logic        exp_changed;

    sensor_scanner #(
        .SETTLE_CYCLES (SETTLE),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .col_in       (col_in),
        .row_sel      (row_sel),
        .sensor_board (sensor_board),
        .frame_done   (frame_done),
        .board_changed(board_changed)
    );

    always #5 clock = ~clock;

    // Sensor matrix: the driven row's presence nibble appears on the columns;
    // with no row driven the lines float to random values.
    always @(negedge clock) begin
        #1;
        col_in = 4'($urandom);
        for (int r = 0; r < 8; r++) begin
            if (row_sel == (8'(1) << r)) col_in = cur_pat[r*4 +: 4] ^ INV;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mdeb[i] = 0;
            mcnt[i] = 0;
        end
        exp_board   = 32'h0;
        exp_changed = 1'b0;
    endtask

    task automatic model_frame(input logic [31:0] pres);
        logic [31:0] nb;
        for (int i = 0; i < 32; i++) begin
            if (int'(pres[i]) == mdeb[i]) begin
                mcnt[i] = 0;
            end else begin
                mcnt[i]++;
                if (mcnt[i] >= DEB) begin
                    mdeb[i] = 1 - mdeb[i];
                    mcnt[i] = 0;
                end
            end
            nb[i] = (mdeb[i] != 0);
        end
        exp_changed = (nb != exp_board);
        exp_board   = nb;
    endtask

    // Present pres for one frame and check the publish; exp_wait>0 also checks cadence.
    task automatic run_frame(input logic [31:0] pres, input int exp_wait, input string tag);
        int n = 0;
        logic [31:0] held;
        cur_pat = pres;
        do begin
            @(negedge clock);
            n++;
        end while (frame_done !== 1'b1 && n < 3 * PERIOD);
        checks++;
        if (frame_done !== 1'b1) begin
            fails++;
            $display("FAIL %s_timeout: frame_done=%b after %0d cycles, required 1", tag, frame_done, n);
        end
        model_frame(pres);
        checks++;
        if (sensor_board !== exp_board) begin
            fails++;
            $display("FAIL %s_board: got %h, required %h", tag, sensor_board, exp_board);
        end
        checks++;
        if (board_changed !== exp_changed) begin
            fails++;
            $display("FAIL %s_changed: got %b, required %b", tag, board_changed, exp_changed);
        end
        if (exp_wait > 0) begin
            checks++;
            if (n != exp_wait) begin
                fails++;
                $display("FAIL %s_period: waited %0d, required %0d", tag, n, exp_wait);
            end
        end
        held = sensor_board;
        @(negedge clock);
        checks++;
        if (frame_done !== 1'b0 || board_changed !== 1'b0 || sensor_board !== held) begin
            fails++;
            $display("FAIL %s_pulse: done=%b changed=%b board=%h, required 0 0 %h",
                     tag, frame_done, board_changed, sensor_board, held);
        end
        $display("frame %s: pres=%h board=%h changed=%b", tag, pres, sensor_board, exp_changed);
    endtask

    task automatic wait_row(input logic [7:0] rs, input string tag);
        int n = 0;
        while (row_sel !== rs && n < 3 * PERIOD) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (row_sel !== rs) begin
            fails++;
            $display("FAIL %s_wait_row: row_sel=%h, required %h", tag, row_sel, rs);
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (row_sel !== 8'h00 || sensor_board !== 32'h0 || frame_done !== 1'b0 || board_changed !== 1'b0) begin
            fails++;
            $display("FAIL reset_values: row_sel=%h board=%h done=%b changed=%b, required all 0",
                     row_sel, sensor_board, frame_done, board_changed);
        end
        reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        checks++;
        if (row_sel !== 8'h00 || frame_done !== 1'b0) begin
            fails++;
            $display("FAIL idle_no_enable: row_sel=%h done=%b, required 00 0", row_sel, frame_done);
        end
        $display("reset: row_sel=%h board=%h", row_sel, sensor_board);
    endtask

    task automatic test_first_frame();
        logic [7:0] exp_rs;
        cur_pat = 32'h0;
        enable  = 1'b1;
        for (int k = 1; k <= PERIOD; k++) begin
            @(negedge clock);
            exp_rs = (k <= 40) ? (8'(1) << ((k - 1) / (SETTLE + 1))) : 8'h00;
            checks++;
            if (row_sel !== exp_rs) begin
                fails++;
                $display("FAIL walk_row_sel: cycle %0d got %h, required %h", k, row_sel, exp_rs);
            end
            checks++;
            if (frame_done !== (k == PERIOD)) begin
                fails++;
                $display("FAIL first_done_timing: cycle %0d frame_done=%b, required %b", k, frame_done, k == PERIOD);
            end
        end
        model_frame(32'h0);
        checks++;
        if (sensor_board !== exp_board || board_changed !== exp_changed) begin
            fails++;
            $display("FAIL first_frame: board=%h changed=%b, required %h %b",
                     sensor_board, board_changed, exp_board, exp_changed);
        end
        $display("first frame: board=%h changed=%b", sensor_board, board_changed);
        @(negedge clock);
    endtask

    task automatic test_single_square();
        for (int f = 1; f <= 4; f++) run_frame(32'h0000_0200, PERIOD - 1, $sformatf("single%0d", f));
    endtask

    task automatic test_glitch();
        for (int f = 0; f < 3; f++) run_frame(32'h0, PERIOD - 1, "clear");
        run_frame(32'h0000_0200, PERIOD - 1, "glitch_on");
        for (int f = 0; f < 3; f++) run_frame(32'h0, PERIOD - 1, $sformatf("glitch_off%0d", f));
    endtask

    task automatic test_random();
        logic [31:0] base;
        for (int f = 0; f < 16; f++) begin
            if (f % 4 == 0) base = $urandom;
            run_frame(base ^ ($urandom & $urandom & $urandom), PERIOD - 1, $sformatf("rand%0d", f));
        end
    endtask

    task automatic test_enable_drop();
        int n = 0;
        int bad = 0;
        logic [31:0] pres;
        pres    = $urandom;
        cur_pat = pres;
        wait_row(8'h08, "drop");
        enable = 1'b0;
        while (frame_done !== 1'b1 && n < 3 * PERIOD) begin
            @(negedge clock);
            n++;
        end
        model_frame(pres);
        checks++;
        if (frame_done !== 1'b1 || sensor_board !== exp_board || board_changed !== exp_changed) begin
            fails++;
            $display("FAIL drop_frame: done=%b board=%h changed=%b, required 1 %h %b",
                     frame_done, sensor_board, board_changed, exp_board, exp_changed);
        end
        for (int k = 0; k < 3 * PERIOD; k++) begin
            @(negedge clock);
            if (row_sel !== 8'h00 || frame_done !== 1'b0 || board_changed !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            fails++;
            $display("FAIL drop_idle: %0d active cycles after enable drop, required 0", bad);
        end
        $display("enable drop: board=%h idle_violations=%0d", sensor_board, bad);
    endtask

    task automatic test_reset_midframe();
        enable = 1'b1;
        for (int f = 0; f < 3; f++) run_frame(32'h0000_0200, 0, "preload");
        cur_pat = 32'h0000_0200;
        wait_row(8'h20, "rst");
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clock);
        checks++;
        if (row_sel !== 8'h00 || sensor_board !== 32'h0 || frame_done !== 1'b0 || board_changed !== 1'b0) begin
            fails++;
            $display("FAIL midframe_reset: row_sel=%h board=%h done=%b changed=%b, required all 0",
                     row_sel, sensor_board, frame_done, board_changed);
        end
        reset = 1'b0;
        model_reset();
        repeat (5) @(negedge clock);
        checks++;
        if (row_sel !== 8'h00 || sensor_board !== 32'h0 || frame_done !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_idle: row_sel=%h board=%h done=%b, required 00 0 0",
                     row_sel, sensor_board, frame_done);
        end
        enable = 1'b1;
        run_frame(32'h0000_0200, 0, "rerun1");
        run_frame(32'h0000_0200, PERIOD - 1, "rerun2");
        checks++;
        if (sensor_board !== 32'h0000_0200) begin
            fails++;
            $display("FAIL rerun_board: got %h, required 00000200", sensor_board);
        end
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_single_square();
        test_glitch();
        test_random();
        test_enable_drop();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
